// File: rtl/rf_pkg.sv
// Shared constants and flattened-bus helpers for the multi-port integer register file.
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int X0_ADDR  = 0;

  // Bit offset of port p within a flattened bus of w-bit fields.
  function automatic int port_slice(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: busy_set marks a pending producer, any enabled write retires it.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWP  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy_set,
  input  logic [AW-1:0]     busy_add,
  input  logic [NWP-1:0]    we,
  input  logic [NWP*AW-1:0] w_add,
  output logic [NREG-1:0]   busy
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == X0_ADDR) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        always_comb begin
          set_hit = busy_set && (busy_add == AW'(gi));
          clr_hit = 1'b0;
          for (int p = 0; p < NWP; p++) begin
            clr_hit = clr_hit | (we[p] && (w_add[port_slice(p, AW) +: AW] == AW'(gi)));
          end
        end
        // A newly issued producer outranks the retiring write on the same register.
        assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multi-port register file with busy scoreboard and combinational reads.
// Define RF_BYPASS_EN to forward same-cycle write data (and clear busy) onto matching reads.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  parameter int NWP  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   w_add,
  input  logic [NWP*XLEN-1:0] w_data,
  input  logic [NRP*AW-1:0]   r_add,
  output logic [NRP*XLEN-1:0] r_data,
  output logic [NRP-1:0]      r_busy,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_add
);

  localparam logic [AW-1:0] X0 = AW'(X0_ADDR);

  logic [XLEN-1:0] mem_reg [NREG];
  logic [NREG-1:0] busy_vec;

  rf_scoreboard #(
    .NREG(NREG),
    .NWP (NWP)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy_set(busy_set),
    .busy_add(busy_add),
    .we      (we),
    .w_add   (w_add),
    .busy    (busy_vec)
  );

  // Ports are applied in ascending order so the highest-index writer wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NWP; p++) begin
        if (we[p] && (w_add[port_slice(p, AW) +: AW] != X0)) begin
          mem_reg[w_add[port_slice(p, AW) +: AW]] <= w_data[port_slice(p, XLEN) +: XLEN];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_rd
      logic [AW-1:0]   rd_addr;
      logic [XLEN-1:0] rd_data;
      logic            rd_busy;

      always_comb begin
        rd_addr = r_add[port_slice(gi, AW) +: AW];
        rd_data = mem_reg[rd_addr];
        rd_busy = busy_vec[rd_addr];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < NWP; p++) begin
          if (we[p] && (rd_addr != X0) && (w_add[port_slice(p, AW) +: AW] == rd_addr)) begin
            rd_data = w_data[port_slice(p, XLEN) +: XLEN];
            rd_busy = busy_set && (busy_add == rd_addr);
          end
        end
`endif
        if (rd_addr == X0) begin
          rd_data = '0;
          rd_busy = 1'b0;
        end
      end

      assign r_data[port_slice(gi, XLEN) +: XLEN] = rd_data;
      assign r_busy[gi] = rd_busy;
    end
  endgenerate

endmodule
